// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the ALU decoder and the execute stage.
//   ALU_WIDTH      : default operand/result width
//   ALU_* codes    : 3-bit ALUControl encoding (100, 110, 111 are undefined)
//   entry_flags_t  : per-entry status bits of a buffered execute result; the
//                    result word is kept beside it because its width is a
//                    parameter of the instantiating module
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef struct packed {
        logic valid;
        logic zero;
        logic illegal;
    } entry_flags_t;

endpackage : alu_pkg

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU: {alu_control, src_a, src_b} -> {result, zero,
// illegal}.
//   alu_control : ALUControl code from the decoder
//   src_a/src_b : operands, WIDTH bits
//   result      : add/sub modulo 2^WIDTH, and, or, signed slt; 0 when illegal
//   zero        : result == 0
//   illegal     : alu_control is not one of the defined codes
// -----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case leaves it unassigned (which would infer a latch).
        result  = '0;
        illegal = 1'b0;
        case (alu_control)
            ALU_ADD: result = src_a + src_b;
            ALU_SUB: result = src_a - src_b;
            ALU_AND: result = src_a & src_b;
            ALU_OR:  result = src_a | src_b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            // Undefined codes and any X on alu_control fall through to here.
            default: illegal = 1'b1;
        endcase
    end

    assign zero = (result == '0);

endmodule : alu_core

// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
// Registered execute stage with valid/ready on both sides and a 2-entry
// (main + skid) output buffer: one op per cycle, 1-cycle latency.
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous discard of all buffered ops
//   in_valid/in_ready   : upstream handshake (in_ready is a register output)
//   alu_control, src_a, src_b : op presented by decode/operand select
//   out_valid/out_ready : downstream handshake
//   alu_result, zero, illegal : contents of the main entry
// -----------------------------------------------------------------------------
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             illegal
);

    logic [WIDTH-1:0] w_result;
    logic             w_zero;
    logic             w_illegal;
    logic             w_accept;
    logic             w_consume;
    entry_flags_t     w_new_flags;

    entry_flags_t     r_m_flags;
    entry_flags_t     r_s_flags;
    logic [WIDTH-1:0] r_m_result;
    logic [WIDTH-1:0] r_s_result;

    alu_core #(.WIDTH(WIDTH)) u_alu_core (
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .result      (w_result),
        .zero        (w_zero),
        .illegal     (w_illegal)
    );

    // Readiness depends only on the skid register, so out_ready never reaches
    // in_ready combinationally.
    assign in_ready  = ~r_s_flags.valid;
    assign w_accept  = in_valid & in_ready;
    assign w_consume = r_m_flags.valid & out_ready;

    assign w_new_flags = '{valid: 1'b1, zero: w_zero, illegal: w_illegal};

    // NOTE: the result registers are reset as well as the valid bits, because
    // alu_result/zero/illegal must read 0 while the stage is in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_flags  <= '0;
            r_s_flags  <= '0;
            r_m_result <= '0;
            r_s_result <= '0;
        end else if (flush) begin
            // Flush beats accept and consume; payloads are left as don't-care.
            r_m_flags.valid <= 1'b0;
            r_s_flags.valid <= 1'b0;
        end else if (!r_m_flags.valid || w_consume) begin
            // Main entry is free this edge: refill from skid first (FIFO order),
            // otherwise from the input, otherwise it goes empty.
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values, regardless of statement order.
            if (r_s_flags.valid) begin
                r_m_flags       <= r_s_flags;
                r_m_result      <= r_s_result;
                r_s_flags.valid <= 1'b0;
            end else if (w_accept) begin
                r_m_flags  <= w_new_flags;
                r_m_result <= w_result;
            end else begin
                r_m_flags.valid <= 1'b0;
            end
        end else if (w_accept) begin
            // Main entry is stalled; the new op parks in the skid entry.
            r_s_flags  <= w_new_flags;
            r_s_result <= w_result;
        end
    end

    assign out_valid  = r_m_flags.valid;
    assign alu_result = r_m_result;
    assign zero       = r_m_flags.zero;
    assign illegal    = r_m_flags.illegal;

endmodule : alu_exec_stage
